// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline-control stage for the 5-stage rv32i core.
// Generates PC/pipeline-register load and flush enables from memory
// handshakes, load-use and branch-mispredict, holds memory responses that
// arrive while the other memory freezes the pipeline, and keeps saturating
// stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             br_mispredict,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  if_instr,
    output logic [XLEN-1:0]  mem_rdata,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_mem_cnt,
    output logic [CNT_W-1:0] stall_lu_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_imem_done_q;
    logic             r_dmem_done_q;
    logic [XLEN-1:0]  r_ibuf;
    logic [XLEN-1:0]  r_dbuf;
    logic [CNT_W-1:0] r_stall_mem_cnt;
    logic [CNT_W-1:0] r_stall_lu_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_i_done;
    logic w_d_done;
    logic w_mem_stall;
    logic w_advance;

    assign w_i_done    = imem_resp | r_imem_done_q;
    assign w_d_done    = dmem_resp | r_dmem_done_q;
    assign w_mem_stall = (imem_req & ~w_i_done) | (dmem_req & ~w_d_done);
    assign w_advance   = ~w_mem_stall;

    assign if_instr      = r_imem_done_q ? r_ibuf : imem_rdata;
    assign mem_rdata     = r_dmem_done_q ? r_dbuf : dmem_rdata;
    assign stall_mem_cnt = r_stall_mem_cnt;
    assign stall_lu_cnt  = r_stall_lu_cnt;
    assign flush_cnt     = r_flush_cnt;

    // Priority: reset > memory stall > load-use bubble > mispredict flush > run
    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst_n && w_advance) begin
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (load_use) begin
                // EX operands are stale, so a concurrent mispredict is ignored
                flush_ex_mem = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                flush_if_id = br_mispredict;
                flush_id_ex = br_mispredict;
            end
        end
    end

    // Sticky capture of responses that land while the other memory stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imem_done_q <= 1'b0;
            r_dmem_done_q <= 1'b0;
            r_ibuf        <= '0;
            r_dbuf        <= '0;
        end else if (w_advance) begin
            r_imem_done_q <= 1'b0;
            r_dmem_done_q <= 1'b0;
        end else begin
            if (imem_resp && !r_imem_done_q) begin
                r_imem_done_q <= 1'b1;
                r_ibuf        <= imem_rdata;
            end
            if (dmem_resp && !r_dmem_done_q) begin
                r_dmem_done_q <= 1'b1;
                r_dbuf        <= dmem_rdata;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_mem_cnt <= '0;
            r_stall_lu_cnt  <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (w_mem_stall && r_stall_mem_cnt != '1)
                r_stall_mem_cnt <= r_stall_mem_cnt + CNT_ONE;
            if (w_advance && load_use && r_stall_lu_cnt != '1)
                r_stall_lu_cnt <= r_stall_lu_cnt + CNT_ONE;
            if (w_advance && !load_use && br_mispredict && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

endmodule
